// File: rtl/mac_dot_pkg.sv
// Shared types and constants for the dot-product sequencer.
package mac_dot_pkg;

   localparam int OP_W    = 8;
   localparam int ACC_W   = 32;
   localparam int MAC_LAT = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_SETTLE,
      S_RESULT
   } dot_state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Drives a multi-cycle MAC through whole dot products; each result is
// the accumulator delta since command acceptance (accumulator never cleared).
module mac_dot_seq
   import mac_dot_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [LEN_W-1:0]        cmd_len,
   input  logic                    op_valid,
   output logic                    op_ready,
   input  logic signed [OP_W-1:0]  op_a,
   input  logic signed [OP_W-1:0]  op_b,
   output logic                    mac_valid,
   output logic signed [OP_W-1:0]  mac_a,
   output logic signed [OP_W-1:0]  mac_b,
   input  logic signed [ACC_W-1:0] mac_y,
   input  logic                    mac_overflow,
   input  logic                    mac_done,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic signed [ACC_W-1:0] res_data,
   output logic                    res_overflow,
   output logic                    res_error,
   output logic                    busy
);

   // A healthy MAC must always finish before the abort fires.
   localparam int TO_EFF = (TIMEOUT > MAC_LAT) ? TIMEOUT : MAC_LAT + 1;
   localparam int WC_W   = $clog2(TO_EFF + 1);

   dot_state_t              state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [WC_W-1:0]         wcnt_q, wcnt_d;
   logic [ACC_W-1:0]        base_q, base_d;
   logic [ACC_W-1:0]        res_q, res_d;
   logic signed [OP_W-1:0]  a_q, a_d;
   logic signed [OP_W-1:0]  b_q, b_d;
   logic                    ovf_q, ovf_d;
   logic                    err_q, err_d;
   logic                    mv_q, mv_d;
   logic                    opr_q, opr_d;
   logic                    rv_q, rv_d;
   logic [ACC_W-1:0]        delta;

   // Modular subtraction keeps the delta correct across accumulator wrap.
   assign delta = mac_y - base_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      base_d  = base_q;
      res_d   = res_q;
      a_d     = a_q;
      b_d     = b_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               len_d  = cmd_len;
               base_d = mac_y;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               err_d  = 1'b0;
               if (cmd_len == '0) begin
                  res_d   = '0;
                  state_d = S_RESULT;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (op_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mac_done) begin
               ovf_d   = ovf_q | mac_overflow;
               cnt_d   = cnt_q + 1'b1;
               state_d = S_SETTLE;
            end else if (wcnt_q == WC_W'(TO_EFF - 1)) begin
               err_d   = 1'b1;
               res_d   = delta;
               state_d = S_RESULT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == len_q) begin
               res_d   = delta;
               state_d = S_RESULT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_RESULT: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      mv_d  = (state_d == S_ISSUE);
      opr_d = (state_d == S_FETCH);
      rv_d  = (state_d == S_RESULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         base_q  <= '0;
         res_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         mv_q    <= 1'b0;
         opr_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         base_q  <= base_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         mv_q    <= mv_d;
         opr_q   <= opr_d;
         rv_q    <= rv_d;
      end
   end

   assign cmd_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign op_ready     = opr_q;
   assign mac_valid    = mv_q;
   assign mac_a        = a_q;
   assign mac_b        = b_q;
   assign res_valid    = rv_q;
   assign res_data     = res_q;
   assign res_overflow = ovf_q;
   assign res_error    = err_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural 3-cycle MAC model.
module tb_mac_dot_seq;

   localparam int LEN_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid, cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic              op_valid, op_ready;
   logic signed [7:0] op_a, op_b;
   logic              mac_valid;
   logic signed [7:0] mac_a, mac_b;
   logic signed [31:0] mac_y;
   logic              mac_overflow, mac_done;
   logic              res_valid, res_ready;
   logic signed [31:0] res_data;
   logic              res_overflow, res_error, busy;

   int total = 0;
   int bad   = 0;
   int mv_cnt = 0;
   int lat;
   int mv0;
   logic signed [31:0] r_data;
   logic              r_ovf, r_err;
   logic signed [7:0] va [8];
   logic signed [7:0] vb [8];

   // MAC model: LOAD, PROCESSING, DONE; sum lands entering DONE.
   logic [1:0]  mst;
   logic [31:0] acc;
   logic        rovf;
   logic        nodone = 1'b0;
   logic        inj_done = 1'b0;
   logic        inj_any = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      int p;
      logic [31:0] s;
      if (reset) begin
         mst  <= 2'd0;
         acc  <= '0;
         rovf <= 1'b0;
      end else begin
         case (mst)
            2'd0: if (mac_valid) mst <= 2'd1;
            2'd1: mst <= 2'd2;
            2'd2: begin
               p = int'(mac_a) * int'(mac_b);
               s = acc + p;
               acc  <= s;
               rovf <= (acc[31] == p[31]) && (s[31] != acc[31]);
               mst  <= 2'd3;
            end
            default: mst <= 2'd0;
         endcase
      end
   end

   assign mac_y        = acc;
   assign mac_done     = (mst == 2'd3) && !nodone;
   assign mac_overflow = (mst == 2'd3) ? (rovf | inj_done) : inj_any;

   always @(posedge clk) if (mac_valid) mv_cnt++;

   mac_dot_seq #(.LEN_W(LEN_W), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b),
      .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
      .mac_y(mac_y), .mac_overflow(mac_overflow), .mac_done(mac_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_overflow(res_overflow),
      .res_error(res_error), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input int n, input int gap, input int hold,
                         output int l);
      int idx, gapc;
      bit acc_op, stl;
      logic [31:0] d0;
      idx = 0;
      gapc = 0;
      cmd_len = LEN_W'(n);
      cmd_valid = 1'b1;
      op_a = va[0];
      op_b = vb[0];
      op_valid = (n > 0);
      chk("cmd_ready_idle", 32'(cmd_ready), 1);
      step();
      cmd_valid = 1'b0;
      l = 1;
      while (!res_valid && l < 300) begin
         acc_op = op_valid && op_ready;
         stl = op_ready && !op_valid && gapc > 0;
         step();
         l++;
         if (acc_op) begin
            idx++;
            if (idx == 1 && gap > 0) gapc = gap;
         end else if (stl) begin
            gapc--;
         end
         op_valid = (idx < n) && (gapc == 0);
         op_a = va[idx & 7];
         op_b = vb[idx & 7];
      end
      if (!res_valid) chk("res_wait_bound", 32'(res_valid), 1);
      r_data = res_data;
      r_ovf = res_overflow;
      r_err = res_error;
      chk("cmd_ready_busy", 32'(cmd_ready), 0);
      d0 = res_data;
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("res_valid_hold", 32'(res_valid), 1);
         chk("res_data_hold", res_data, d0);
         chk("cmd_ready_hold", 32'(cmd_ready), 0);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("cmd_ready_after", 32'(cmd_ready), 1);
      chk("res_valid_after", 32'(res_valid), 0);
      chk("busy_after", 32'(busy), 0);
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_len = '0;
      op_valid = 1'b0;
      op_a = '0;
      op_b = '0;
      res_ready = 1'b0;
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_op_ready", 32'(op_ready), 0);
      chk("rst_mac_valid", 32'(mac_valid), 0);
      chk("rst_res_data", res_data, 0);
      step();
      step();
      reset = 1'b0;
      step();

      // (2,3) (-4,5) (7,7) -> 35
      va[0] = 2;  vb[0] = 3;
      va[1] = -4; vb[1] = 5;
      va[2] = 7;  vb[2] = 7;
      mv0 = mv_cnt;
      do_cmd(3, 0, 0, lat);
      chk("t1_lat", lat, 19);
      chk("t1_data", r_data, 35);
      chk("t1_ovf", 32'(r_ovf), 0);
      chk("t1_err", 32'(r_err), 0);
      chk("t1_mac_pulses", mv_cnt - mv0, 3);

      // base 35 removed
      va[0] = -128; vb[0] = -128;
      va[1] = 127;  vb[1] = 127;
      do_cmd(2, 0, 0, lat);
      chk("t2_lat", lat, 13);
      chk("t2_data", r_data, 32513);
      chk("t2_mac_y", mac_y, 32548);

      mv0 = mv_cnt;
      do_cmd(0, 0, 0, lat);
      chk("t3_lat", lat, 1);
      chk("t3_data", r_data, 0);
      chk("t3_mac_pulses", mv_cnt - mv0, 0);

      // operand stall, result backpressure, stray overflow outside done
      va[0] = 1;  vb[0] = 2;
      va[1] = 3;  vb[1] = 4;
      va[2] = -5; vb[2] = 6;
      inj_any = 1'b1;
      do_cmd(3, 5, 4, lat);
      inj_any = 1'b0;
      chk("t4_lat", lat, 24);
      chk("t4_data", r_data, -16);
      chk("t4_ovf", 32'(r_ovf), 0);

      va[0] = 2; vb[0] = 2;
      inj_done = 1'b1;
      do_cmd(1, 0, 0, lat);
      inj_done = 1'b0;
      chk("t5_lat", lat, 7);
      chk("t5_data", r_data, 4);
      chk("t5_ovf", 32'(r_ovf), 1);

      va[0] = 3; vb[0] = 4;
      nodone = 1'b1;
      do_cmd(1, 0, 0, lat);
      nodone = 1'b0;
      chk("t6_lat", lat, 18);
      chk("t6_err", 32'(r_err), 1);
      chk("t6_ovf", 32'(r_ovf), 0);
      chk("t6_data", r_data, 12);

      // reset during WAIT of element 2
      cmd_valid = 1'b1;
      cmd_len = 8'd3;
      op_valid = 1'b1;
      op_a = 1;
      op_b = 1;
      step();
      cmd_valid = 1'b0;
      repeat (9) step();
      chk("t7_busy_pre", 32'(busy), 1);
      chk("t7_mac_valid_pre", 32'(mac_valid), 0);
      reset = 1'b1;
      op_valid = 1'b0;
      #1;
      chk("t7_busy", 32'(busy), 0);
      chk("t7_cmd_ready", 32'(cmd_ready), 1);
      chk("t7_op_ready", 32'(op_ready), 0);
      chk("t7_mac_valid", 32'(mac_valid), 0);
      chk("t7_res_valid", 32'(res_valid), 0);
      chk("t7_res_ovf", 32'(res_overflow), 0);
      chk("t7_res_err", 32'(res_error), 0);
      chk("t7_res_data", res_data, 0);
      chk("t7_mac_a", 32'(mac_a), 0);
      chk("t7_mac_b", 32'(mac_b), 0);
      chk("t7_mac_y", mac_y, 0);
      step();
      reset = 1'b0;
      step();
      chk("t7_no_result", 32'(res_valid), 0);

      va[0] = 5; vb[0] = -6;
      do_cmd(1, 0, 0, lat);
      chk("t8_lat", lat, 7);
      chk("t8_data", r_data, -30);
      chk("t8_mac_y", mac_y, -30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

- Sequencer that drives one `mac_int_fsm` instance through complete dot products.
- Accepts a command carrying a vector length and streams that many signed 8-bit operand pairs into the MAC over its valid/done handshake.
- Returns the 32-bit dot-product result and an overflow flag on a ready/valid result port.
- Sits between the operand/command fabric and the MAC; the MAC accumulator is never reset between commands. Per-command results come from base-subtraction.

## Interface
- `LEN_W`, default 8: width of the command length field.
- `TIMEOUT`, default 15: maximum cycles in WAIT before the command aborts.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high. It is shared with the MAC instance.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_len` in LEN_W: command handshake and element count (0 allowed).
- `op_valid` in 1, `op_ready` out 1: operand handshake.
- `op_a`, `op_b` in 8 signed: operand pair.
- `mac_valid` out 1: start pulse to the MAC.
- `mac_a`, `mac_b` out 8 signed: operands to the MAC, held stable while the element is in flight.
- `mac_y` in 32 signed, `mac_overflow` in 1, `mac_done` in 1: MAC outputs.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 32 signed: dot-product result.
- `res_overflow` out 1: the MAC reported overflow during this command.
- `res_error` out 1: the command aborted on timeout.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, SETTLE, RESULT.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_len` into `len_q`, capture `mac_y` into `base_q`, clear `cnt`, `ovf_q` and `err_q`.
  - Next state is RESULT if `cmd_len`==0, else FETCH.
- FETCH
  - `op_ready`=1.
  - On `op_valid`: register `op_a`/`op_b` into `mac_a`/`mac_b`, then go to ISSUE.
  - Otherwise stay in FETCH (no limit).
- ISSUE: `mac_valid`=1 for exactly one cycle, then WAIT.
- WAIT
  - Hold `mac_a`/`mac_b` and count cycles.
  - On `mac_done`: `ovf_q |= mac_overflow`, `cnt++`, go to SETTLE.
  - If the wait count reaches `TIMEOUT` without `mac_done`: set `err_q`, go to RESULT.
- SETTLE: `mac_y` now holds the updated sum. If `cnt`==`len_q` go to RESULT, else FETCH.
- RESULT
  - On entry, register `res_data` = `mac_y` − `base_q`, using 32-bit modular subtraction (wraps correctly across accumulator wrap).
  - `res_valid`=1. Hold `res_data`, `res_overflow`, `res_error` stable until `res_ready`, then go to IDLE.
  - On timeout abort, `res_data` = `mac_y` − `base_q` (partial).
- `mac_overflow` is only sampled in the cycle `mac_done`=1. Its value at any other time is ignored.
- `op_ready` is low in every state except FETCH. `cmd_ready` is low in every state except IDLE.

## Timing
- Reset (asynchronous):
  - State returns to IDLE.
  - `mac_valid`, `op_ready`, `res_valid`, `res_overflow`, `res_error`, `busy` = 0.
  - `mac_a`, `mac_b`, `res_data`, `base_q`, `cnt` = 0.
  - `cmd_ready` = 1 (decoded from IDLE).
- Per element with `op_valid` held high: 6 cycles.
  - FETCH 1, ISSUE 1, WAIT 3 (MAC LOAD/PROCESSING/DONE), SETTLE 1.
- Command accepted in cycle t0:
  - `res_valid` first high at t0+1+6N.
  - For N=0, `res_valid` is high at t0+1.
- Back-to-back: the next `cmd_ready` comes the cycle after the result handshake completes.
- Reset mid-command:
  - The command is dropped and no result is produced.
  - The MAC accumulator is also cleared by the shared reset.

## Structure
- Package `mac_dot_pkg` holds:
  - the state typedef `dot_state_t`;
  - `MAC_LAT` = 3 (cycles from `mac_valid` to `mac_done`);
  - `OP_W` = 8 and `ACC_W` = 32.
- No sub-module inside `mac_dot_seq`.
- The pairing with `mac_int_fsm` is done one level up in `mac_dot_top`, which is also the verification top.

## Test plan
- Pairs (2,3), (−4,5), (7,7) with `cmd_len`=3 from reset: expect `res_data`=35, `res_overflow`=0, `res_error`=0, `res_valid` at t0+19.
- Directly after that, pairs (−128,−128), (127,127) with `cmd_len`=2: expect `res_data`=32513 (base 35 removed) and `mac_y`=32548.
- `cmd_len`=0: expect `res_valid` at t0+1, `res_data`=0, `mac_valid` never asserted.
- `op_valid` low for 5 cycles mid-vector and `res_ready` low for 4 cycles:
  - expect the result unchanged;
  - expect `res_data` stable while `res_valid` is high;
  - expect `cmd_ready`=0 until the result handshake.
- Tie `mac_done`=0 with `cmd_len`=1: expect `res_valid` with `res_error`=1 after `TIMEOUT` WAIT cycles, then IDLE.
- Assert `reset` during WAIT of element 2 of 3: expect all outputs at reset values and `mac_y`=0. A following `cmd_len`=1 command with (5,−6) gives −30.
